// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS load/store unit: operation and FSM encodings,
// byte-offset mask and the misalignment rule.
package mips_cpu_pkg;

  typedef enum logic [2:0] {LB, LBU, LH, LHU, LW, SB, SH, SW} lsu_op_t;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} lsu_state_t;

  // Byte-offset bits inside a word; cleared to form the memory word address.
  localparam logic [1:0] LSU_WORD_MASK = 2'b11;

  function automatic logic lsu_misaligned(lsu_op_t op, logic [1:0] lo);
    case (op)
      LH, LHU, SH: return lo[0];
      LW, SW:      return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_rmw_if.sv
// CPU request/response channel plus word-memory bus of the load/store unit.
// slave = the LSU itself, master = CPU core and data memory around it.
interface mips_cpu_lsu_rmw_if
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  lsu_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_exc;
  logic [ADDR_W-1:0] data_address;
  logic              data_write;
  logic              data_read;
  logic [31:0]       data_writedata;
  logic [31:0]       data_readdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, data_readdata,
    output req_ready, resp_valid, resp_rdata, resp_exc,
           data_address, data_write, data_read, data_writedata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, data_readdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
           data_address, data_write, data_read, data_writedata
  );
endinterface

// File: rtl/mips_cpu_lsu_lane.sv
// Little-endian lane logic: extracts/extends sub-word loads from a memory
// word and merges sub-word store data into it.
module mips_cpu_lsu_lane
  import mips_cpu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic signed [7:0]  byte_v;
  logic signed [15:0] half_v;

  always_comb begin
    byte_v    = word[{lane, 3'b000} +: 8];
    half_v    = word[{lane[1], 4'b0000} +: 16];
    load_data = '0;
    merged    = word;
    case (op)
      LB:  load_data = 32'(byte_v);
      LBU: load_data = {24'b0, byte_v};
      LH:  load_data = 32'(half_v);
      LHU: load_data = {16'b0, half_v};
      LW:  load_data = word;
      SB:  merged[{lane, 3'b000} +: 8]    = wdata[7:0];
      SH:  merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SW:  merged = wdata;
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_cpu_lsu_rmw.sv
// Load/store unit in front of the word-only data memory: sub-word loads become
// read+extract, SB/SH become read-modify-write. Build option LSU_MISALIGN_TRAP_EN
// answers misaligned accesses immediately with resp_exc instead of aligning them.
module mips_cpu_lsu_rmw
  import mips_cpu_pkg::*;
#(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_W           = 32
) (
  input logic               clk,
  input logic               reset,
  mips_cpu_lsu_rmw_if.slave bus
);
  localparam logic [2:0] CNT_LOAD = 3'(MEM_READ_LATENCY - 1);

  lsu_state_t        state, state_d;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word_q, load_data, merged;
  logic [2:0]        cnt;
  logic              exc_q, trap, accept, is_rmw;
  logic              req_ready, data_read, data_write, resp_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = lsu_misaligned(bus.req_op, bus.req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept = bus.req_valid && (state == IDLE);
  assign is_rmw = (op_q == SB) || (op_q == SH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_d = trap ? DONE : (bus.req_op == SW) ? WR : RD;
      end
      RD: begin
        data_read = 1'b1;
        state_d   = WAIT;
      end
      WAIT: if (cnt == '0) state_d = is_rmw ? WR : DONE;
      WR: begin
        data_write = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at accept; the read word is taken when the wait count expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= LB;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      cnt     <= '0;
      exc_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        exc_q   <= trap;
      end
      if (state == RD)                      cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)  cnt <= cnt - 3'd1;
      if (state == WAIT && cnt == '0)       word_q <= bus.data_readdata;
    end
  end

  mips_cpu_lsu_lane u_lane (
    .op        (op_q),
    .lane      (addr_q[1:0]),
    .word      (word_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign bus.req_ready      = req_ready;
  assign bus.data_read      = data_read;
  assign bus.data_write     = data_write;
  assign bus.resp_valid     = resp_valid;
  assign bus.resp_exc       = resp_valid && exc_q;
  assign bus.resp_rdata     = (resp_valid && !exc_q) ? load_data : '0;
  assign bus.data_writedata = data_write ? merged : '0;
  assign bus.data_address   = {addr_q[ADDR_W-1:2], addr_q[1:0] & ~LSU_WORD_MASK};
endmodule

// File: tb/tb_mips_cpu_lsu_rmw.sv
// Scoreboard bench for mips_cpu_lsu_rmw: two instances (read latency 1 and 3)
// behind word memories, checked against a word-array reference model.
module tb_mips_cpu_lsu_rmw;
  import mips_cpu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [31:0] waddr;
    int          acc;
    int          cyc;
    int          wr;
    int          rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid_a [2];
  lsu_op_t     req_op_a [2];
  logic [31:0] req_addr_a [2];
  logic [31:0] req_wdata_a [2];
  logic        req_ready_a [2];
  logic        resp_valid_a [2];
  logic        resp_exc_a [2];
  logic        rd_a [2];
  logic        wr_a [2];
  logic [31:0] resp_rdata_a [2];
  logic [31:0] addr_a [2];
  logic [31:0] wdata_a [2];
  int          wr_tot_a [2];
  int          rd_tot_a [2];

  exp_t        q [2][$];
  logic [31:0] ref_mem [2][64];
  int          exp_wr [2];
  int          exp_rd [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    mips_cpu_lsu_rmw_if #(.ADDR_W(32)) bus ();
    logic [31:0] mem [64];
    logic [31:0] pipe_d [LAT];
    logic        pipe_v [LAT];
    int          wr_tot;
    int          rd_tot;

    mips_cpu_lsu_rmw #(.MEM_READ_LATENCY(LAT), .ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.req_valid     = req_valid_a[g];
    assign bus.req_op        = req_op_a[g];
    assign bus.req_addr      = req_addr_a[g];
    assign bus.req_wdata     = req_wdata_a[g];
    assign bus.data_readdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0_BAD0;
    assign req_ready_a[g]    = bus.req_ready;
    assign resp_valid_a[g]   = bus.resp_valid;
    assign resp_exc_a[g]     = bus.resp_exc;
    assign resp_rdata_a[g]   = bus.resp_rdata;
    assign rd_a[g]           = bus.data_read;
    assign wr_a[g]           = bus.data_write;
    assign addr_a[g]         = bus.data_address;
    assign wdata_a[g]        = bus.data_writedata;
    assign wr_tot_a[g]       = wr_tot;
    assign rd_tot_a[g]       = rd_tot;

    // Word memory: read data appears LAT cycles after the read strobe, poisoned otherwise.
    always @(posedge clk) begin
      if (mem_clear) begin
        for (int i = 0; i < 64; i++) mem[i] <= '0;
        wr_tot <= 0;
        rd_tot <= 0;
      end else begin
        if (bus.data_write) begin
          mem[bus.data_address[7:2]] <= bus.data_writedata;
          wr_tot <= wr_tot + 1;
        end
        if (bus.data_read) rd_tot <= rd_tot + 1;
      end
      pipe_v[0] <= bus.data_read;
      pipe_d[0] <= mem[bus.data_address[7:2]];
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, k, cyc, act, req);
  endfunction

  // Monitor: protocol checks every cycle, scoreboard pop on each response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          chk("rst_req_ready", k, 32'(req_ready_a[k]), 1);
          chk("rst_data_read", k, 32'(rd_a[k]), 0);
          chk("rst_data_write", k, 32'(wr_a[k]), 0);
          chk("rst_resp_valid", k, 32'(resp_valid_a[k]), 0);
          chk("rst_resp_exc", k, 32'(resp_exc_a[k]), 0);
          chk("rst_resp_rdata", k, resp_rdata_a[k], 0);
          chk("rst_data_address", k, addr_a[k], 0);
          chk("rst_data_writedata", k, wdata_a[k], 0);
        end else begin
          if (rd_a[k] || wr_a[k]) chk("strobe_overlap", k, 32'(rd_a[k] & wr_a[k]), 0);
          if (q[k].size() > 0) begin
            if (cyc == q[k][0].acc + 1) chk("busy_req_ready", k, 32'(req_ready_a[k]), 0);
            if (rd_a[k] || wr_a[k]) chk("data_address", k, addr_a[k], q[k][0].waddr);
          end
          if (resp_valid_a[k]) begin
            chk("resp_expected", k, 32'(q[k].size() > 0), 1);
            if (q[k].size() > 0) begin
              e = q[k].pop_front();
              chk("resp_rdata", k, resp_rdata_a[k], e.rdata);
              chk("resp_exc", k, 32'(resp_exc_a[k]), 32'(e.exc));
              chk("resp_cycle", k, cyc, e.cyc);
              chk("write_count", k, wr_tot_a[k], e.wr);
              chk("read_count", k, rd_tot_a[k], e.rd);
            end
          end
        end
      end
    end
  end

  task automatic wait_ready(int k);
    int n = 0;
    @(negedge clk);
    while (!req_ready_a[k]) begin
      @(negedge clk);
      n++;
      if (n > 64) begin
        $display("FAIL req_ready_timeout inst%0d: got busy, expected idle within 64 cycles", k);
        $fatal(1, "bench stopped: request never accepted");
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q[0].size() != 0 || q[1].size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL resp_timeout: got %0d/%0d pending, expected 0", q[0].size(), q[1].size());
        $fatal(1, "bench stopped: responses missing");
      end
    end
    @(negedge clk);
  endtask

  // Reference model: word array, lanes and latency computed from the op rules.
  task automatic issue(int k, lsu_op_t op, logic [31:0] addr, logic [31:0] wd);
    exp_t        e;
    int          lat, idx, bl, hl, sv;
    int          lat_mem;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    bit          mis;
    lat_mem = (k == 0) ? 1 : 3;
    idx = int'(addr[7:2]);
    bl  = int'(addr[1:0]);
    hl  = int'(addr[1]);
    w   = ref_mem[k][idx];
    b   = 8'(w >> (8 * bl));
    h   = 16'(w >> (16 * hl));
    mis = ((op == LH || op == LHU || op == SH) && addr[0]) ||
          ((op == LW || op == SW) && addr[1:0] != 2'b00);
`ifndef LSU_MISALIGN_TRAP_EN
    mis = 1'b0;
`endif
    e.rdata = '0;
    e.exc   = 1'b0;
    e.waddr = {addr[31:2], 2'b00};
    if (mis) begin
      e.exc = 1'b1;
      lat   = 1;
    end else begin
      case (op)
        LB:  begin sv = $signed(b); e.rdata = sv; end
        LBU: e.rdata = 32'(b);
        LH:  begin sv = $signed(h); e.rdata = sv; end
        LHU: e.rdata = 32'(h);
        LW:  e.rdata = w;
        SB:  ref_mem[k][idx] = (w & ~(32'hFF << (8 * bl))) | ((wd & 32'hFF) << (8 * bl));
        SH:  ref_mem[k][idx] = (w & ~(32'hFFFF << (16 * hl))) | ((wd & 32'hFFFF) << (16 * hl));
        default: ref_mem[k][idx] = wd;
      endcase
      if (op != SW) exp_rd[k]++;
      if (op == SB || op == SH || op == SW) exp_wr[k]++;
      lat = (op == SW) ? 2 : (op == SB || op == SH) ? 3 + lat_mem : 2 + lat_mem;
    end
    e.wr = exp_wr[k];
    e.rd = exp_rd[k];
    wait_ready(k);
    req_valid_a[k] = 1'b1;
    req_op_a[k]    = op;
    req_addr_a[k]  = addr;
    req_wdata_a[k] = wd;
    e.acc = cyc;
    e.cyc = cyc + lat;
    q[k].push_back(e);
    @(posedge clk);
    #1;
    req_op_a[k]    = lsu_op_t'($urandom_range(0, 7));
    req_addr_a[k]  = $urandom;
    req_wdata_a[k] = $urandom;
    @(posedge clk);
    #1;
    req_valid_a[k] = 1'b0;
  endtask

  task automatic abort_sh(logic [31:0] addr, logic [31:0] wd);
    wait_ready(0);
    req_valid_a[0] = 1'b1;
    req_op_a[0]    = SH;
    req_addr_a[0]  = addr;
    req_wdata_a[0] = wd;
    exp_rd[0]++;
    @(posedge clk);
    #1;
    req_valid_a[0] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int          k;
    logic [31:0] ra;
    reset     = 1'b0;
    mem_clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid_a[i] = 1'b0;
      req_op_a[i]    = LB;
      req_addr_a[i]  = '0;
      req_wdata_a[i] = '0;
      exp_wr[i]      = 0;
      exp_rd[i]      = 0;
      for (int j = 0; j < 64; j++) ref_mem[i][j] = '0;
    end
    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    reset     = 1'b1;

    for (int i = 0; i < 2; i++) begin
      issue(i, SH,  32'h10, 32'hFFFF_FFF0);
      issue(i, LW,  32'h10, 32'h0);
      issue(i, SW,  32'h14, 32'h1122_3344);
      issue(i, SB,  32'h16, 32'h0000_00AA);
      issue(i, LW,  32'h14, 32'h0);
      issue(i, LB,  32'h16, 32'h0);
      issue(i, LBU, 32'h16, 32'h0);
      issue(i, SW,  32'h18, 32'h8001_7FFF);
      issue(i, LH,  32'h1A, 32'h0);
      issue(i, LHU, 32'h18, 32'h0);
      issue(i, SW,  32'h20, 32'hDEAD_BEEF);
      issue(i, LW,  32'h20, 32'h0);
      issue(i, LW,  32'h21, 32'h0);
    end
    drain();

    abort_sh(32'h10, 32'h0000_1234);
    issue(0, LW, 32'h10, 32'h0);
    drain();

    repeat (300) begin
      k  = int'($urandom_range(0, 1));
      ra = $urandom;
      issue(k, lsu_op_t'($urandom_range(0, 7)), ra, $urandom);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mips_cpu_lsu_rmw.md
Name: mips_cpu_lsu_rmw

Overview:
- CPU-side initiator for the data memory port of mips_cpu_harvard; drives the data_address/data_write/data_read/data_writedata/data_readdata bus into mips_cpu_data_memory.
- Converts sub-word loads (LB/LBU/LH/LHU) into a word read plus byte/halfword extract with sign or zero extension.
- Converts SB/SH into read-modify-write over the word-only memory; LW/SW pass through as a single access.
- Little-endian lanes: byte offset 0 is bits[7:0], so SH to offset 0 lands in bits[15:0].

Parameters:
- MEM_READ_LATENCY, 1: cycles from the data_read cycle until data_readdata is valid (1..7).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  CPU request strobe
- req_ready  out  1  high only in IDLE
- req_op  in  3  lsu_op_t: LB, LBU, LH, LHU, LW, SB, SH, SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word stores use low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores
- resp_exc  out  1  misaligned-access flag, valid with resp_valid
- data_address  out  32  word-aligned memory address (low 2 bits = 0)
- data_write  out  1  memory write strobe
- data_read  out  1  memory read strobe
- data_writedata  out  32  memory write word
- data_readdata  in  32  memory read word

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; req_ready=1; resp_valid=0; resp_exc=0; resp_rdata=0; data_write=0; data_read=0; data_address=0; data_writedata=0; wait counter=0.
- A request is accepted on a rising edge with req_valid&&req_ready. op, addr and wdata are latched at that edge; input changes afterwards are ignored until the next accept.
- States and transitions:
  - IDLE: on accept, SW -> WR; any other op -> RD.
  - RD: data_read=1 for exactly one cycle -> WAIT; counter loads MEM_READ_LATENCY-1.
  - WAIT: data_read=0; while counter!=0, decrement and stay. When counter==0, capture data_readdata at that edge; then loads -> DONE, SB/SH -> WR.
  - WR: data_write=1 for exactly one cycle; data_writedata = merged word (SB/SH) or wdata (SW) -> DONE.
  - DONE: resp_valid=1 for one cycle -> IDLE.
- data_read and data_write are never high in the same cycle. data_address is held at {addr[31:2],2'b00} from RD/WR entry through DONE.
- Latency at MEM_READ_LATENCY=1, counted from the accept edge:
  - SW: data_write in cycle +1, resp_valid in cycle +2.
  - Loads: data_read +1, capture +2, resp_valid +3.
  - SB/SH: data_read +1, capture +2, data_write +3, resp_valid +4.
- Each extra latency cycle adds one WAIT cycle.
- Extract: byte lane = addr[1:0]; halfword lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend.
- Merge: replace only the addressed lane(s) of the captured word with wdata[7:0] or wdata[15:0]; all other bits are unchanged.
- req_valid during a busy state: not accepted; req_ready=0. A new request is accepted in the cycle after DONE at the earliest.
- reset asserted mid-operation: any pending write is dropped, strobes drop immediately, state returns to IDLE. No partial write is issued after reset release.
- Misalignment (see feature below): LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned accept goes IDLE -> DONE with no memory strobe. resp_valid fires at +1 with resp_exc=1 and resp_rdata=0.
- Undefined: misaligned low address bits are silently cleared (halfword aligns to addr[1], word to 00). resp_exc is tied 0.

Decomposition:
- Package mips_cpu_pkg: typedef enum lsu_op_t {LB,LBU,LH,LHU,LW,SB,SH,SW}, typedef enum lsu_state_t {IDLE,RD,WAIT,WR,DONE}, constant LSU_WORD_MASK.
- One combinational sub-module, mips_cpu_lsu_lane, performs the extract/extend and merge functions. The FSM stays in the top module.

Test Plan:
- Memory word at 0x10 = 0; SH wdata=0xFFFFFFF0 addr=0x10; then LW 0x10 -> resp_rdata=0x0000FFF0; exactly one data_write.
- Word 0x14 = 0x11223344; SB wdata=0xAA addr=0x16 -> word becomes 0x11AA3344; then LB 0x16 -> 0xFFFFFFAA and LBU 0x16 -> 0x000000AA.
- Word 0x18 = 0x8001_7FFF; LH 0x1A -> 0xFFFF8001; LHU 0x18 -> 0x00007FFF.
- SW 0xDEADBEEF to 0x20 -> data_write in cycle +1, resp_valid in cycle +2, data_read never asserted; with MEM_READ_LATENCY=3, an LW to the same address yields resp_valid at +5.
- Drop reset to 0 during WAIT of an SH -> strobes 0 immediately, no data_write ever issued, memory word unchanged, req_ready=1 after release.
- With LSU_MISALIGN_TRAP_EN: LW addr=0x21 -> resp_valid +1, resp_exc=1, no strobes. Without it: the same request reads word 0x20.
